mcd_rd_cmd_adapter: RTL and testbench

MCD_RD_CMD_ADAPTER -- requirements
Module: mcd_rd_cmd_adapter

---
 rtl/mcd_rd_cmd_adapter.sv | 119 +++++++++++
 tb/tb_mcd_rd_cmd_adapter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcd_rd_cmd_adapter.sv
// Converts mcd byte-addressed read commands into 512-byte-sector HBA read
// commands, split into MAX_SECT-sized chunks, with a num_words push per command.
//
// state | meaning
// IDLE  | waiting for an mcd read command (ready when link up and FIFO has space)
// CALC  | num_words strobe is out; set up the first HBA chunk
// ISSUE | presenting HBA read chunks until the whole command is sent
module mcd_rd_cmd_adapter #(
    parameter int MAX_SECT = 16
) (
    input  logic        clk,
    input  logic        nReset,
    input  logic [31:0] dramRdCmd_address,
    input  logic [15:0] dramRdCmd_count,
    input  logic        dramRdCmd_valid,
    output logic        dramRdCmd_ready,
    output logic [47:0] hba_rd_lba,
    output logic [15:0] hba_rd_sect,
    output logic        hba_rd_valid,
    input  logic        hba_rd_ready,
    input  logic        link_initialized,
    output logic [15:0] num_words,
    output logic        rd_num_words_en,
    input  logic        nw_full_n,
    output logic        addr_err,
    output logic [1:0]  state_de,
    output logic [15:0] cmd_cnt_de
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam logic [7:0] MAX8 = 8'(MAX_SECT);

    state_t      r_state;
    logic [22:0] r_addr_sect;
    logic [15:0] r_count;
    logic [7:0]  r_rem;

    logic        w_accept;
    logic [7:0]  w_rem_init;
    logic [7:0]  w_rem_next;
    logic        w_last;

    function automatic logic [7:0] f_chunk(input logic [7:0] rem);
        return (rem > MAX8) ? MAX8 : rem;
    endfunction

    assign dramRdCmd_ready = (r_state == IDLE) && link_initialized && nw_full_n;
    assign w_accept        = dramRdCmd_valid && dramRdCmd_ready;
    assign w_rem_init      = 8'(({1'b0, r_count} + 17'd511) >> 9);
    assign w_rem_next      = r_rem - hba_rd_sect[7:0];
    assign w_last          = (r_rem <= MAX8);
    assign state_de        = r_state;

    always_ff @(posedge clk) begin
        if (!nReset) begin
            r_state         <= IDLE;
            r_addr_sect     <= '0;
            r_count         <= '0;
            r_rem           <= '0;
            hba_rd_valid    <= 1'b0;
            hba_rd_lba      <= '0;
            hba_rd_sect     <= '0;
            num_words       <= '0;
            rd_num_words_en <= 1'b0;
            addr_err        <= 1'b0;
            cmd_cnt_de      <= '0;
        end else begin
            rd_num_words_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_addr_sect <= dramRdCmd_address[31:9];
                        r_count     <= dramRdCmd_count;
                        cmd_cnt_de  <= cmd_cnt_de + 16'd1;
                        if (dramRdCmd_address[8:0] != 9'd0)
                            addr_err <= 1'b1;
                        // Strobe is registered here so it is high for the whole CALC cycle.
                        if (dramRdCmd_count != 16'd0) begin
                            num_words       <= 16'(({1'b0, dramRdCmd_count} + 17'd3) >> 2);
                            rd_num_words_en <= 1'b1;
                        end
                        r_state <= CALC;
                    end
                end
                CALC: begin
                    if (r_count != 16'd0) begin
                        r_rem        <= w_rem_init;
                        hba_rd_lba   <= {25'd0, r_addr_sect};
                        hba_rd_sect  <= {8'd0, f_chunk(w_rem_init)};
                        hba_rd_valid <= 1'b1;
                        r_state      <= ISSUE;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                ISSUE: begin
                    // Chunk is held until the HBA takes it, regardless of link state.
                    if (hba_rd_ready) begin
                        hba_rd_lba <= hba_rd_lba + {32'd0, hba_rd_sect};
                        r_rem      <= w_rem_next;
                        if (w_last) begin
                            hba_rd_valid <= 1'b0;
                            r_state      <= IDLE;
                        end else begin
                            hba_rd_sect <= {8'd0, f_chunk(w_rem_next)};
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mcd_rd_cmd_adapter.sv
// Bench for mcd_rd_cmd_adapter: directed scenarios plus random traffic, checked
// against a command-level model (expected pushes and HBA chunks kept in queues).
module tb_mcd_rd_cmd_adapter;

    localparam int MAXS = 16;

    logic        clk = 1'b0;
    logic        nReset = 1'b0;
    logic [31:0] dramRdCmd_address = '0;
    logic [15:0] dramRdCmd_count = '0;
    logic        dramRdCmd_valid = 1'b0;
    logic        dramRdCmd_ready;
    logic [47:0] hba_rd_lba;
    logic [15:0] hba_rd_sect;
    logic        hba_rd_valid;
    logic        hba_rd_ready = 1'b0;
    logic        link_initialized = 1'b0;
    logic [15:0] num_words;
    logic        rd_num_words_en;
    logic        nw_full_n = 1'b0;
    logic        addr_err;
    logic [1:0]  state_de;
    logic [15:0] cmd_cnt_de;

    always #5 clk = ~clk;

    mcd_rd_cmd_adapter #(.MAX_SECT(MAXS)) dut (
        .clk(clk), .nReset(nReset),
        .dramRdCmd_address(dramRdCmd_address), .dramRdCmd_count(dramRdCmd_count),
        .dramRdCmd_valid(dramRdCmd_valid), .dramRdCmd_ready(dramRdCmd_ready),
        .hba_rd_lba(hba_rd_lba), .hba_rd_sect(hba_rd_sect),
        .hba_rd_valid(hba_rd_valid), .hba_rd_ready(hba_rd_ready),
        .link_initialized(link_initialized), .num_words(num_words),
        .rd_num_words_en(rd_num_words_en), .nw_full_n(nw_full_n),
        .addr_err(addr_err), .state_de(state_de), .cmd_cnt_de(cmd_cnt_de)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [47:0] lba;
        int          sect;
        int          id;
    } rd_t;

    rd_t         rq[$];
    int          nwq[$];
    int          nw_id_q[$];
    int          cmd_id = 0;
    int          last_push_id = -1;
    bit          m_out = 1'b0;
    bit          m_zero = 1'b0;
    logic [15:0] m_cnt = '0;
    bit          m_err = 1'b0;

    logic        n_rst = 1'b0, n_valid = 1'b0, n_link = 1'b1, n_full = 1'b1, n_hrdy = 1'b1;
    logic [31:0] n_addr = '0;
    logic [15:0] n_count = '0;

    task automatic model_cmd(input logic [31:0] a, input logic [15:0] c);
        int          ci;
        int          rem;
        int          s;
        logic [47:0] lba;
        ci = int'(c);
        m_cnt++;
        if (a % 512 != 0) m_err = 1'b1;
        if (ci == 0) begin
            m_zero = 1'b1;
        end else begin
            nwq.push_back((ci + 3) / 4);
            nw_id_q.push_back(cmd_id);
            rem = (ci + 511) / 512;
            lba = 48'(a / 512);
            while (rem > 0) begin
                s = (rem > MAXS) ? MAXS : rem;
                rq.push_back('{lba, s, cmd_id});
                lba = lba + 48'(s);
                rem = rem - s;
            end
        end
        cmd_id++;
        m_out = 1'b1;
    endtask

    // One clock: check outputs after the edge, then apply next inputs and advance the model.
    task automatic cycle();
        bit cur_out;
        int id;
        @(posedge clk);
        #1;
        chk("cmd_cnt", cmd_cnt_de, m_cnt);
        chk("addr_err", addr_err, m_err);
        if (rd_num_words_en) begin
            if (nwq.size() == 0) chk("nw_unexpected", 1, 0);
            else begin
                chk("num_words", num_words, nwq[0]);
                last_push_id = nw_id_q[0];
                void'(nwq.pop_front());
                void'(nw_id_q.pop_front());
            end
        end
        if (hba_rd_valid) begin
            if (rq.size() == 0) chk("rd_unexpected", 1, 0);
            else begin
                chk("hba_lba", hba_rd_lba, rq[0].lba);
                chk("hba_sect", hba_rd_sect, rq[0].sect);
                chk("push_before_rd", (rq[0].id <= last_push_id), 1);
            end
        end
        nReset           = n_rst;
        dramRdCmd_valid  = n_valid;
        dramRdCmd_address = n_addr;
        dramRdCmd_count  = n_count;
        link_initialized = n_link;
        nw_full_n        = n_full;
        hba_rd_ready     = n_hrdy;
        #1;
        cur_out = m_out;
        chk("cmd_ready", dramRdCmd_ready, !cur_out && n_link && n_full);
        if (!n_rst) begin
            rq.delete();
            nwq.delete();
            nw_id_q.delete();
            m_out = 1'b0;
            m_zero = 1'b0;
            m_cnt = '0;
            m_err = 1'b0;
            last_push_id = cmd_id - 1;
        end else begin
            if (hba_rd_valid && n_hrdy && rq.size() > 0) begin
                id = rq[0].id;
                void'(rq.pop_front());
                if (rq.size() == 0 || rq[0].id != id) m_out = 1'b0;
            end else if (m_zero) begin
                m_zero = 1'b0;
                m_out = 1'b0;
            end
            if (n_valid && !cur_out && n_link && n_full)
                model_cmd(n_addr, n_count);
        end
    endtask

    task automatic quiet();
        n_rst = 1'b1; n_valid = 1'b0; n_link = 1'b1; n_full = 1'b1; n_hrdy = 1'b1;
    endtask

    task automatic drain();
        quiet();
        for (int i = 0; i < 400; i++) begin
            if (!m_out && rq.size() == 0 && nwq.size() == 0) break;
            cycle();
        end
        cycle();
        chk("drain_busy", m_out, 0);
        chk("drain_reads_left", rq.size(), 0);
        chk("drain_push_left", nwq.size(), 0);
    endtask

    task automatic send(input logic [31:0] a, input logic [15:0] c);
        n_valid = 1'b1; n_addr = a; n_count = c;
        cycle();
        n_valid = 1'b0;
    endtask

    logic [47:0] hold_lba;
    logic [15:0] hold_sect;
    logic [15:0] hold_cnt;
    logic [31:0] r32;

    initial begin
        n_rst = 1'b0;
        cycle();
        cycle();
        chk("rst_state", state_de, 0);
        chk("rst_valid", hba_rd_valid, 0);
        chk("rst_nw", num_words, 0);
        quiet();
        cycle();

        // Small single-sector read
        send(32'h0000_0400, 16'd100);
        cycle();
        chk("d1_calc_state", state_de, 1);
        chk("d1_nw", num_words, 25);
        chk("d1_nw_en", rd_num_words_en, 1);
        cycle();
        chk("d1_lba", hba_rd_lba, 48'd2);
        chk("d1_sect", hba_rd_sect, 16'd1);
        cycle();
        chk("d1_idle", state_de, 0);
        chk("d1_valid_low", hba_rd_valid, 0);

        // 40 sectors split into back-to-back chunks
        send(32'h0010_0000, 16'd20480);
        cycle();
        chk("d2_nw", num_words, 5120);
        cycle();
        chk("d2_lba0", hba_rd_lba, 48'h800);
        cycle();
        chk("d2_lba1", hba_rd_lba, 48'h810);
        cycle();
        chk("d2_lba2", hba_rd_lba, 48'h820);
        chk("d2_sect2", hba_rd_sect, 16'd8);
        cycle();
        chk("d2_idle", state_de, 0);

        // Zero-length command
        send(32'h0000_2000, 16'd0);
        cycle();
        chk("d3_no_push", rd_num_words_en, 0);
        cycle();
        chk("d3_no_rd", hba_rd_valid, 0);
        chk("d3_ready_again", dramRdCmd_ready, 1);

        // Back-pressure from HBA with link toggling
        n_hrdy = 1'b0;
        send(32'h0010_0000, 16'd20480);
        cycle();
        cycle();
        hold_lba = hba_rd_lba;
        hold_sect = hba_rd_sect;
        for (int i = 0; i < 4; i++) begin
            n_link = logic'(i % 2);
            cycle();
            chk("d4_hold_valid", hba_rd_valid, 1);
            chk("d4_hold_lba", hba_rd_lba, hold_lba);
            chk("d4_hold_sect", hba_rd_sect, hold_sect);
        end
        n_link = 1'b1;
        n_hrdy = 1'b1;
        cycle();
        cycle();
        chk("d4_advance", hba_rd_lba, 48'h810);
        drain();

        // Acceptance blocked by FIFO full or link down
        hold_cnt = cmd_cnt_de;
        n_valid = 1'b1; n_addr = 32'h0000_1000; n_count = 16'd64; n_full = 1'b0;
        cycle();
        cycle();
        chk("d5_full_ready", dramRdCmd_ready, 0);
        n_full = 1'b1; n_link = 1'b0;
        cycle();
        cycle();
        chk("d5_link_ready", dramRdCmd_ready, 0);
        chk("d5_cnt_held", cmd_cnt_de, hold_cnt);
        quiet();
        cycle();

        // Misaligned address, then reset while issuing
        n_hrdy = 1'b0;
        send(32'h0000_0201, 16'd100);
        cycle();
        cycle();
        chk("d6_err", addr_err, 1);
        chk("d6_lba", hba_rd_lba, 48'd1);
        n_rst = 1'b0;
        cycle();
        n_rst = 1'b1;
        cycle();
        chk("d6_rst_valid", hba_rd_valid, 0);
        chk("d6_rst_err", addr_err, 0);
        chk("d6_rst_state", state_de, 0);
        drain();

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            n_rst   = ($urandom_range(0, 999) != 0);
            n_valid = ($urandom_range(0, 99) < 50);
            n_link  = ($urandom_range(0, 99) < 90);
            n_full  = ($urandom_range(0, 99) < 85);
            n_hrdy  = ($urandom_range(0, 99) < 60);
            r32 = $urandom;
            n_addr = ($urandom_range(0, 9) == 0) ? r32 : {r32[31:9], 9'd0};
            case ($urandom_range(0, 9))
                0:       n_count = 16'd0;
                1:       n_count = 16'd20480;
                2, 3:    n_count = 16'($urandom_range(1, 512));
                4:       n_count = 16'hFFFF;
                default: n_count = 16'($urandom_range(0, 65535));
            endcase
            cycle();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
